// File: rtl/pulse_seq_bank.sv
// pulse_seq_bank: N_CHAN independent laser pulse sequencers (initial/high/low/burst per channel).
// Define PSEQ_READBACK_EN to add the registered config readback port reg_rdata.
module pulse_seq_bank #(
    parameter int unsigned N_CHAN = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_wr,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic [CNT_W-1:0]  reg_data,
    input  logic [N_CHAN-1:0] start,
    input  logic [N_CHAN-1:0] stop,
    output logic [N_CHAN-1:0] laser_en,
    output logic [N_CHAN-1:0] running,
    output logic [N_CHAN-1:0] done
`ifdef PSEQ_READBACK_EN
    ,
    output logic [CNT_W-1:0]  reg_rdata
`endif
);

    localparam int unsigned CH_W = ADDR_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_HIGH, S_LOW} state_t;

    logic [CH_W-1:0]  addr_ch;
    logic [1:0]       addr_fld;
    logic [CNT_W-1:0] cfg_init  [N_CHAN];
    logic [CNT_W-1:0] cfg_low   [N_CHAN];
    logic [CNT_W-1:0] cfg_high  [N_CHAN];
    logic [CNT_W-1:0] cfg_burst [N_CHAN];

    assign addr_ch  = reg_addr[ADDR_W-1:2];
    assign addr_fld = reg_addr[1:0];

    // A programmed length of 0 behaves as 1 cycle.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    for (genvar i = 0; i < int'(N_CHAN); i++) begin : g_chan
        logic             wr_hit;
        state_t           state;
        logic [CNT_W-1:0] phase;
        logic [CNT_W-1:0] pulses;
        logic [CNT_W-1:0] shadow;
        logic             laser_q;
        logic             run_q;
        logic             done_q;

        assign wr_hit      = reg_wr && (addr_ch == CH_W'(i));
        assign laser_en[i] = laser_q;
        assign running[i]  = run_q;
        assign done[i]     = done_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cfg_init[i]  <= '0;
                cfg_low[i]   <= '0;
                cfg_high[i]  <= '0;
                cfg_burst[i] <= '0;
            end else if (wr_hit) begin
                case (addr_fld)
                    2'd0: cfg_init[i]  <= reg_data;
                    2'd1: cfg_low[i]   <= reg_data;
                    2'd2: cfg_high[i]  <= reg_data;
                    2'd3: cfg_burst[i] <= reg_data;
                endcase
            end
        end

        // Outputs are assigned alongside the state they describe, so they track next-state.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= S_IDLE;
                phase   <= '0;
                pulses  <= '0;
                shadow  <= '0;
                laser_q <= 1'b0;
                run_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (stop[i]) begin
                    state   <= S_IDLE;
                    laser_q <= 1'b0;
                    run_q   <= 1'b0;
                end else if (start[i]) begin
                    state   <= S_INIT;
                    phase   <= phase_load(cfg_init[i]);
                    pulses  <= '0;
                    shadow  <= cfg_burst[i];
                    laser_q <= 1'b0;
                    run_q   <= 1'b1;
                end else begin
                    case (state)
                        S_IDLE: begin
                            laser_q <= 1'b0;
                            run_q   <= 1'b0;
                        end
                        S_INIT: begin
                            if (phase == '0) begin
                                state   <= S_HIGH;
                                phase   <= phase_load(cfg_high[i]);
                                laser_q <= 1'b1;
                            end else begin
                                phase <= phase - CNT_W'(1);
                            end
                        end
                        S_HIGH: begin
                            if (phase == '0) begin
                                state   <= S_LOW;
                                phase   <= phase_load(cfg_low[i]);
                                pulses  <= pulses + CNT_W'(1);
                                laser_q <= 1'b0;
                            end else begin
                                phase <= phase - CNT_W'(1);
                            end
                        end
                        S_LOW: begin
                            if (phase == '0) begin
                                if (shadow != '0 && pulses == shadow) begin
                                    state  <= S_IDLE;
                                    run_q  <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    state   <= S_HIGH;
                                    phase   <= phase_load(cfg_high[i]);
                                    laser_q <= 1'b1;
                                end
                            end else begin
                                phase <= phase - CNT_W'(1);
                            end
                        end
                    endcase
                end
            end
        end
    end

`ifdef PSEQ_READBACK_EN
    logic [CNT_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            if (addr_ch == CH_W'(c)) begin
                case (addr_fld)
                    2'd0: rd_mux = cfg_init[c];
                    2'd1: rd_mux = cfg_low[c];
                    2'd2: rd_mux = cfg_high[c];
                    2'd3: rd_mux = cfg_burst[c];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_rdata <= '0;
        end else begin
            reg_rdata <= rd_mux;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_seq_bank.sv
// Self-checking bench for pulse_seq_bank: segment-based waveform model plus directed literal checks.
module tb_pulse_seq_bank;

    localparam int NC = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        reg_wr   = 1'b0;
    logic [5:0]  reg_addr = '0;
    logic [31:0] reg_data = '0;
    logic [3:0]  start    = '0;
    logic [3:0]  stop     = '0;
    logic [3:0]  laser_en;
    logic [3:0]  running;
    logic [3:0]  done;
`ifdef PSEQ_READBACK_EN
    logic [31:0] reg_rdata;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pulse_seq_bank #(
        .N_CHAN(4),
        .CNT_W (32),
        .ADDR_W(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .start    (start),
        .stop     (stop),
        .laser_en (laser_en),
        .running  (running),
        .done     (done)
`ifdef PSEQ_READBACK_EN
        ,
        .reg_rdata(reg_rdata)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel emits a sequence of constant-level segments whose lengths are
    // taken from the configuration at the moment the segment begins.
    int unsigned m_cfg [NC][4];
    int unsigned m_left   [NC];
    int unsigned m_pulses [NC];
    int unsigned m_shadow [NC];
    bit          m_next_high [NC];
    bit [3:0]    m_act;
    bit [3:0]    m_laser;
    bit [3:0]    m_done;

    function automatic int unsigned eff(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                for (int f = 0; f < 4; f++) m_cfg[c][f] = 0;
                m_left[c] = 0;
                m_pulses[c] = 0;
                m_shadow[c] = 0;
                m_next_high[c] = 1'b0;
            end
            m_act = '0;
            m_laser = '0;
            m_done = '0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                m_done[c] = 1'b0;
                if (stop[c]) begin
                    m_act[c] = 1'b0;
                    m_laser[c] = 1'b0;
                end else if (start[c]) begin
                    m_act[c] = 1'b1;
                    m_laser[c] = 1'b0;
                    m_pulses[c] = 0;
                    m_shadow[c] = m_cfg[c][3];
                    m_next_high[c] = 1'b1;
                    m_left[c] = eff(m_cfg[c][0]) - 1;
                end else if (m_act[c]) begin
                    if (m_left[c] != 0) begin
                        m_left[c]--;
                    end else if (m_next_high[c]) begin
                        if (m_shadow[c] != 0 && m_pulses[c] == m_shadow[c]) begin
                            m_act[c] = 1'b0;
                            m_done[c] = 1'b1;
                            m_laser[c] = 1'b0;
                        end else begin
                            m_pulses[c]++;
                            m_laser[c] = 1'b1;
                            m_left[c] = eff(m_cfg[c][2]) - 1;
                            m_next_high[c] = 1'b0;
                        end
                    end else begin
                        m_laser[c] = 1'b0;
                        m_left[c] = eff(m_cfg[c][1]) - 1;
                        m_next_high[c] = 1'b1;
                    end
                end
            end
            if (reg_wr && reg_addr[5:2] < 4'd4)
                m_cfg[reg_addr[5:2]][reg_addr[1:0]] = reg_data;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_laser_en", 32'(laser_en), 32'(m_laser));
            check("cyc_running", 32'(running), 32'(m_act));
            check("cyc_done", 32'(done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        reg_wr = 1'b1;
        reg_addr = a;
        reg_data = d;
        tick();
        reg_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  pat_zero;
        logic [15:0] pat_ch0;
        int          rises;
        int          dones;
        int          n;
        int          len;
        logic        prev;

        pat_zero = 6'b101010;
        pat_ch0  = 16'b1100000000110000;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;
        check("reset_laser_en", 32'(laser_en), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Reset mid-run clears outputs without waiting for a clock edge.
        wr(6'd0, 32'd5);
        start = 4'b0001;
        tick();
        start = '0;
        check("run_after_start", 32'(running[0]), 32'd1);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_laser_en", 32'(laser_en), 32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // All registers zero: 1 cycle INIT, then alternating 1 high / 1 low.
        start = 4'b0001;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (j == 0) start = '0;
            check("zero_cfg_pattern", 32'(laser_en[0]), 32'(pat_zero[j]));
        end
        stop = 4'b0001;
        tick();
        stop = '0;

        // Ch0: initial 4, high 2, low 8, free-running.
        wr(6'd0, 32'd4);
        wr(6'd1, 32'd8);
        wr(6'd2, 32'd2);
        start = 4'b0001;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (j == 0) start = '0;
            check("ch0_pattern", 32'(laser_en[0]), 32'(pat_ch0[j]));
        end
        repeat (10) tick();
        check("ch0_still_running", 32'(running[0]), 32'd1);
        stop = 4'b0001;
        tick();
        stop = '0;
        check("ch0_stop_laser", 32'(laser_en[0]), 32'd0);
        check("ch0_stop_running", 32'(running[0]), 32'd0);
        check("ch0_stop_no_done", 32'(done[0]), 32'd0);

        // Ch1: burst of 3; a burst rewrite mid-run must not shorten it.
        wr(6'd6, 32'd3);
        wr(6'd5, 32'd5);
        wr(6'd7, 32'd3);
        rises = 0;
        dones = 0;
        start = 4'b0010;
        tick();
        start = '0;
        prev = laser_en[1];
        for (int j = 0; j < 40; j++) begin
            if (j == 1) begin
                reg_wr = 1'b1;
                reg_addr = 6'd7;
                reg_data = 32'd1;
            end else begin
                reg_wr = 1'b0;
            end
            tick();
            if (laser_en[1] && !prev) rises++;
            prev = laser_en[1];
            if (done[1]) begin
                dones++;
                check("ch1_running_at_done", 32'(running[1]), 32'd0);
            end
        end
        check("ch1_pulse_count", 32'(rises), 32'd3);
        check("ch1_done_count", 32'(dones), 32'd1);

        // Ch2: high changed 4 -> 6 during a HIGH phase.
        wr(6'd10, 32'd4);
        wr(6'd9, 32'd2);
        start = 4'b0100;
        tick();
        start = '0;
        n = 0;
        while (!laser_en[2] && n < 10) begin
            tick();
            n++;
        end
        check("ch2_rise_seen", 32'(laser_en[2]), 32'd1);
        len = 0;
        reg_wr = 1'b1;
        reg_addr = 6'd10;
        reg_data = 32'd6;
        while (laser_en[2] && len < 20) begin
            tick();
            reg_wr = 1'b0;
            len++;
        end
        check("ch2_first_pulse_len", 32'(len), 32'd4);
        n = 0;
        while (!laser_en[2] && n < 10) begin
            tick();
            n++;
        end
        check("ch2_second_rise_seen", 32'(laser_en[2]), 32'd1);
        len = 0;
        while (laser_en[2] && len < 20) begin
            tick();
            len++;
        end
        check("ch2_second_pulse_len", 32'(len), 32'd6);

        // start and stop together: stop wins, running or idle.
        start = 4'b0100;
        stop  = 4'b0100;
        tick();
        start = '0;
        stop  = '0;
        check("ch2_startstop_running", 32'(running[2]), 32'd0);
        check("ch2_startstop_laser", 32'(laser_en[2]), 32'd0);
        start = 4'b0100;
        stop  = 4'b0100;
        tick();
        start = '0;
        stop  = '0;
        check("ch2_startstop_idle", 32'(running[2]), 32'd0);

        // Writes to channel 5 are dropped; then equal configs on ch0 and ch3.
        wr(6'd22, 32'd9);
        wr(6'd20, 32'd9);
        for (int f = 0; f < 4; f++) begin
            wr(6'(f), (f == 0) ? 32'd2 : (f == 1) ? 32'd1 : (f == 2) ? 32'd3 : 32'd2);
            wr(6'(12 + f), (f == 0) ? 32'd2 : (f == 1) ? 32'd1 : (f == 2) ? 32'd3 : 32'd2);
        end
        start = 4'b1011;
        tick();
        start = '0;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("ch0_ch3_equal_laser", 32'(laser_en[3]), 32'(laser_en[0]));
            check("ch0_ch3_equal_done", 32'(done[3]), 32'(done[0]));
        end
        stop = 4'b1111;
        tick();
        stop = '0;

`ifdef PSEQ_READBACK_EN
        wr(6'd6, 32'h1234);
        tick();
        check("rb_addr6", reg_rdata, 32'h1234);
        reg_wr = 1'b1;
        reg_data = 32'h55;
        tick();
        reg_wr = 1'b0;
        check("rb_same_cycle_old", reg_rdata, 32'h1234);
        tick();
        check("rb_addr6_new", reg_rdata, 32'h55);
        reg_addr = 6'd20;
        tick();
        check("rb_addr20_zero", reg_rdata, 32'd0);
`endif

        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
